// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one asynchronous SRAM port between the instruction-fetch path and the
//   data path. Data requests take fixed priority over fetches. The FSM walks
//   IDLE -> READ/WRITE (WAIT_CYCLES+1 strobe cycles) -> ACK -> IDLE. Every SRAM
//   pin and both ack/rdata outputs come straight from flops.
//   Optional feature macro: SRAM_FETCH_BUF_EN adds a one-entry fetch buffer
//   that answers repeat fetches of the same word without touching the SRAM.
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch requester
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_ack,
    // data requester
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ack,
    // pipeline stall
    output logic              stall_o,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    // Counter must hold 0..WAIT_CYCLES; keep at least one bit when WAIT_CYCLES=0.
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t            state_reg, state_next;
    owner_t            owner_reg, owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       dq_o_reg, dq_o_next;
    logic              dq_oe_reg, dq_oe_next;
    logic              ce_n_reg, ce_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic [3:0]        be_n_reg, be_n_next;

    logic              inst_ack_reg, inst_ack_next;
    logic              data_ack_reg, data_ack_next;
    logic [31:0]       inst_rdata_reg, inst_rdata_next;
    logic [31:0]       data_rdata_reg, data_rdata_next;

`ifdef SRAM_FETCH_BUF_EN
    logic              buf_valid_reg, buf_valid_next;
    logic [ADDR_W-1:0] buf_tag_reg, buf_tag_next;
    logic [31:0]       buf_data_reg, buf_data_next;
    logic              buf_hit;

    // A fetch of the most recently read instruction word can skip the SRAM.
    assign buf_hit = buf_valid_reg && (buf_tag_reg == inst_addr);
`endif

    // Stall while any requester is waiting for its completion pulse.
    assign stall_o = (inst_req & ~inst_ack) | (data_req & ~data_ack);

    assign sram_addr  = addr_reg;
    assign sram_dq_o  = dq_o_reg;
    assign sram_dq_oe = dq_oe_reg;
    assign sram_ce_n  = ce_n_reg;
    assign sram_oe_n  = oe_n_reg;
    assign sram_we_n  = we_n_reg;
    assign sram_be_n  = be_n_reg;
    assign inst_ack   = inst_ack_reg;
    assign data_ack   = data_ack_reg;
    assign inst_rdata = inst_rdata_reg;
    assign data_rdata = data_rdata_reg;

    // State, owner, counter and every registered output; reset forces strobes idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_INST;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            dq_o_reg       <= '0;
            dq_oe_reg      <= 1'b0;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            be_n_reg       <= 4'hF;
            inst_ack_reg   <= 1'b0;
            data_ack_reg   <= 1'b0;
            inst_rdata_reg <= '0;
            data_rdata_reg <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            dq_o_reg       <= dq_o_next;
            dq_oe_reg      <= dq_oe_next;
            ce_n_reg       <= ce_n_next;
            oe_n_reg       <= oe_n_next;
            we_n_reg       <= we_n_next;
            be_n_reg       <= be_n_next;
            inst_ack_reg   <= inst_ack_next;
            data_ack_reg   <= data_ack_next;
            inst_rdata_reg <= inst_rdata_next;
            data_rdata_reg <= data_rdata_next;
        end
    end

`ifdef SRAM_FETCH_BUF_EN
    // Fetch buffer storage; reset drops the valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
        end else begin
            buf_valid_reg <= buf_valid_next;
            buf_tag_reg   <= buf_tag_next;
            buf_data_reg  <= buf_data_next;
        end
    end
`endif

    // Next-state logic; pin values are computed for the state being entered so
    // that the flops present them during that state.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        dq_o_next       = dq_o_reg;
        dq_oe_next      = 1'b0;
        ce_n_next       = 1'b1;
        oe_n_next       = 1'b1;
        we_n_next       = 1'b1;
        be_n_next       = 4'hF;
        inst_ack_next   = 1'b0;
        data_ack_next   = 1'b0;
        inst_rdata_next = inst_rdata_reg;
        data_rdata_next = data_rdata_reg;
`ifdef SRAM_FETCH_BUF_EN
        buf_valid_next  = buf_valid_reg;
        buf_tag_next    = buf_tag_reg;
        buf_data_next   = buf_data_reg;
`endif

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (data_req) begin
                    // Data path wins whenever it is requesting.
                    owner_next = OWN_DATA;
                    addr_next  = data_addr;
                    ce_n_next  = 1'b0;
                    if (data_we) begin
                        state_next = WRITE;
                        we_n_next  = 1'b0;
                        be_n_next  = ~data_be;
                        dq_oe_next = 1'b1;
                        dq_o_next  = data_wdata;
`ifdef SRAM_FETCH_BUF_EN
                        // A store over the buffered word makes the copy stale.
                        if (buf_valid_reg && (buf_tag_reg == data_addr)) begin
                            buf_valid_next = 1'b0;
                        end
`endif
                    end else begin
                        state_next = READ;
                        oe_n_next  = 1'b0;
                        be_n_next  = 4'h0;
                    end
                end else if (inst_req) begin
                    owner_next = OWN_INST;
`ifdef SRAM_FETCH_BUF_EN
                    if (buf_hit) begin
                        // Answer from the buffer: straight to ACK, SRAM stays idle.
                        state_next      = ACK;
                        inst_ack_next   = 1'b1;
                        inst_rdata_next = buf_data_reg;
                    end else
`endif
                    begin
                        state_next = READ;
                        addr_next  = inst_addr;
                        ce_n_next  = 1'b0;
                        oe_n_next  = 1'b0;
                        be_n_next  = 4'h0;
                    end
                end
            end

            READ: begin
                if (cnt_reg == CNT_LAST) begin
                    // Last strobe cycle: sample the bus for the owner and release strobes.
                    state_next = ACK;
                    cnt_next   = '0;
                    if (owner_reg == OWN_DATA) begin
                        data_rdata_next = sram_dq_i;
                        data_ack_next   = 1'b1;
                    end else begin
                        inst_rdata_next = sram_dq_i;
                        inst_ack_next   = 1'b1;
`ifdef SRAM_FETCH_BUF_EN
                        buf_valid_next  = 1'b1;
                        buf_tag_next    = inst_addr;
                        buf_data_next   = sram_dq_i;
`endif
                    end
                end else begin
                    cnt_next  = cnt_reg + CNT_W'(1);
                    ce_n_next = 1'b0;
                    oe_n_next = 1'b0;
                    be_n_next = 4'h0;
                end
            end

            WRITE: begin
                if (cnt_reg == CNT_LAST) begin
                    // Strobes rise but the data bus stays driven through ACK for hold time.
                    state_next    = ACK;
                    cnt_next      = '0;
                    data_ack_next = 1'b1;
                    dq_oe_next    = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    ce_n_next  = 1'b0;
                    we_n_next  = 1'b0;
                    be_n_next  = ~data_be;
                    dq_oe_next = 1'b1;
                    dq_o_next  = data_wdata;
                end
            end

            ACK: begin
                // Always pass through IDLE so the acked requester can drop its request.
                state_next = IDLE;
                cnt_next   = '0;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter: a W=1 instance against a small SRAM
//   model, plus a W=3 instance whose read bus is driven per cycle by the bench.
//   Expectations follow SRAM_FETCH_BUF_EN when the macro is defined.
module tb_sram_port_arbiter;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_init = 1'b1;

    // W=1 instance
    logic          inst_req = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic [31:0]   inst_rdata;
    logic          inst_ack;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [3:0]    data_be = 4'h0;
    logic [AW-1:0] data_addr = '0;
    logic [31:0]   data_wdata = '0;
    logic [31:0]   data_rdata;
    logic          data_ack;
    logic          stall_o;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [31:0]   sram_dq_i;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [3:0]    sram_be_n;

    // W=3 instance
    logic          data_req_w3 = 1'b0;
    logic [AW-1:0] data_addr_w3 = '0;
    logic [31:0]   inst_rdata_w3, data_rdata_w3;
    logic          inst_ack_w3, data_ack_w3, stall_w3;
    logic [AW-1:0] sram_addr_w3;
    logic [31:0]   sram_dq_o_w3;
    logic          sram_dq_oe_w3;
    logic [31:0]   sram_dq_i_w3 = '0;
    logic          sram_ce_n_w3, sram_oe_n_w3, sram_we_n_w3;
    logic [3:0]    sram_be_n_w3;

    logic [31:0]   mem [0:1023];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
        .stall_o(stall_o),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_port_arbiter #(.WAIT_CYCLES(3), .ADDR_W(AW)) dut_w3 (
        .clk(clk), .rst(rst),
        .inst_req(1'b0), .inst_addr('0), .inst_rdata(inst_rdata_w3), .inst_ack(inst_ack_w3),
        .data_req(data_req_w3), .data_we(1'b0), .data_be(4'h0), .data_addr(data_addr_w3),
        .data_wdata(32'h0), .data_rdata(data_rdata_w3), .data_ack(data_ack_w3),
        .stall_o(stall_w3),
        .sram_addr(sram_addr_w3), .sram_dq_o(sram_dq_o_w3), .sram_dq_oe(sram_dq_oe_w3),
        .sram_dq_i(sram_dq_i_w3),
        .sram_ce_n(sram_ce_n_w3), .sram_oe_n(sram_oe_n_w3), .sram_we_n(sram_we_n_w3),
        .sram_be_n(sram_be_n_w3)
    );

    // SRAM model: asynchronous read while ce_n/oe_n low, byte-masked write on clock edges.
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[10'h200] <= 32'h12345678;
            mem[10'h100] <= 32'hCAFEF00D;
            mem[10'h040] <= 32'h0BADC0DE;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_dq_o[8*b +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One access on the W=1 instance: one idle cycle, raise the request, count
    // cycles and strobe activity until the owner's ack, then drop the request.
    task automatic do_access(input logic is_data, input logic we, input logic [3:0] be,
                             input logic [AW-1:0] addr, input logic [31:0] wdata,
                             output int lat, output int ce_cnt, output int oe_cnt,
                             output int we_cnt, output logic [3:0] be_seen,
                             output logic [31:0] rdata);
        lat = -1; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; be_seen = 4'hF; rdata = '0;
        @(posedge clk); @(negedge clk);
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (!sram_ce_n) begin ce_cnt++; be_seen = sram_be_n; end
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (is_data ? data_ack : inst_ack) begin
                lat = n;
                rdata = is_data ? data_rdata : inst_rdata;
                break;
            end
        end
        data_req = 1'b0;
        inst_req = 1'b0;
        $display("txn %s we=%0b addr=0x%05h lat=%0d ce=%0d rdata=0x%08h",
                 is_data ? "data" : "inst", we, addr, lat, ce_cnt, rdata);
    endtask

    initial begin
        int lat, ce_cnt, oe_cnt, we_cnt;
        logic [3:0] be_seen;
        logic [31:0] rdata;
        int d_ack_at, i_ack_at, i_read_at, stall_gaps, other_acks;

        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;

        // 1: idle after reset
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check_eq("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check_eq("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check_eq("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check_eq("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check_eq("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check_eq("rst_acks", {30'b0, inst_ack, data_ack}, 32'd0);
        check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
        check_eq("rst_addr", {12'b0, sram_addr}, 32'd0);
        check_eq("rst_rdata", inst_rdata | data_rdata, 32'd0);
        $display("txn reset idle checked");

        // 2: partial write then read back
        do_access(1'b1, 1'b1, 4'b0011, 20'h00010, 32'hDEADBEEF, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("wr_lat", lat, 32'd3);
        check_eq("wr_we_cycles", we_cnt, 32'd2);
        check_eq("wr_ce_cycles", ce_cnt, 32'd2);
        check_eq("wr_be_n", {28'b0, be_seen}, 32'hC);
        check_eq("wr_ack_dq_oe_hold", {31'b0, sram_dq_oe}, 32'd1);
        check_eq("wr_ack_dq_hold", sram_dq_o, 32'hDEADBEEF);
        check_eq("wr_ack_we_n", {30'b0, sram_we_n, sram_ce_n}, 32'd3);
        @(posedge clk); @(negedge clk);
        check_eq("wr_dq_oe_drop", {31'b0, sram_dq_oe}, 32'd0);
        check_eq("wr_ack_single", {31'b0, data_ack}, 32'd0);
        do_access(1'b1, 1'b0, 4'h0, 20'h00010, 32'h0, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("rd_lat", lat, 32'd3);
        check_eq("rd_oe_cycles", oe_cnt, 32'd2);
        check_eq("rd_rdata", rdata, 32'h0000BEEF);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check_eq("rd_rdata_held", data_rdata, 32'h0000BEEF);

        // 3: simultaneous fetch and data read
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 20'h00100;
        data_req = 1'b1; data_we = 1'b0; data_addr = 20'h00200;
        d_ack_at = -1; i_ack_at = -1; i_read_at = -1; stall_gaps = 0; other_acks = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (i_read_at < 0 && !sram_ce_n && sram_addr == 20'h00100) i_read_at = n;
            if (inst_ack && data_ack) other_acks++;
            if (data_ack) begin
                d_ack_at = n;
                check_eq("arb_data_rdata", data_rdata, 32'h12345678);
                data_req = 1'b0;
            end
            if (inst_ack) begin
                i_ack_at = n;
                check_eq("arb_inst_rdata", inst_rdata, 32'hCAFEF00D);
                inst_req = 1'b0;
                break;
            end
            if (!stall_o) stall_gaps++;
        end
        inst_req = 1'b0; data_req = 1'b0;
        $display("txn arb data_ack=%0d inst_read=%0d inst_ack=%0d", d_ack_at, i_read_at, i_ack_at);
        check_eq("arb_data_ack_at", d_ack_at, 32'd3);
        check_eq("arb_inst_read_at", i_read_at, 32'd5);
        check_eq("arb_inst_ack_at", i_ack_at, 32'd7);
        check_eq("arb_stall_gaps", stall_gaps, 32'd0);
        check_eq("arb_dual_ack", other_acks, 32'd0);

        // 4: reset during the first WRITE cycle
        @(posedge clk); @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
        data_addr = 20'h00020; data_wdata = 32'h11223344;
        @(posedge clk); #1;
        check_eq("rw_we_n_before", {31'b0, sram_we_n}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rw_strobes_rst", {29'b0, sram_we_n, sram_ce_n, sram_dq_oe}, 32'd6);
        data_req = 1'b0;
        @(negedge clk);
        check_eq("rw_no_ack_a", {31'b0, data_ack}, 32'd0);
        @(posedge clk); @(negedge clk);
        check_eq("rw_no_ack_b", {31'b0, data_ack}, 32'd0);
        rst = 1'b0;
        do_access(1'b1, 1'b1, 4'hF, 20'h00020, 32'h11223344, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("rw_reissue_lat", lat, 32'd3);
        do_access(1'b1, 1'b0, 4'h0, 20'h00020, 32'h0, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("rw_readback", rdata, 32'h11223344);

        // 5: WAIT_CYCLES=3 read, bus value changes every cycle
        @(posedge clk); @(negedge clk);
        data_req_w3 = 1'b1; data_addr_w3 = 20'h00300;
        lat = -1; oe_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (data_ack_w3) begin lat = n; break; end
            if (!sram_oe_n_w3) oe_cnt++;
            sram_dq_i_w3 = 32'h55000000 | n;
        end
        data_req_w3 = 1'b0;
        $display("txn w3 read lat=%0d oe=%0d rdata=0x%08h", lat, oe_cnt, data_rdata_w3);
        check_eq("w3_lat", lat, 32'd5);
        check_eq("w3_oe_cycles", oe_cnt, 32'd4);
        check_eq("w3_rdata", data_rdata_w3, 32'h55000004);

        // 6: repeated fetch, then store to the fetched word
        do_access(1'b0, 1'b0, 4'h0, 20'h00040, 32'h0, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("fb_first_lat", lat, 32'd3);
        check_eq("fb_first_rdata", rdata, 32'h0BADC0DE);
        do_access(1'b0, 1'b0, 4'h0, 20'h00040, 32'h0, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
`ifdef SRAM_FETCH_BUF_EN
        check_eq("fb_hit_lat", lat, 32'd1);
        check_eq("fb_hit_ce", ce_cnt, 32'd0);
`else
        check_eq("fb_second_lat", lat, 32'd3);
        check_eq("fb_second_ce", ce_cnt, 32'd2);
`endif
        check_eq("fb_second_rdata", rdata, 32'h0BADC0DE);
        do_access(1'b1, 1'b1, 4'hF, 20'h00040, 32'hFEEDFACE, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("fb_store_lat", lat, 32'd3);
        do_access(1'b0, 1'b0, 4'h0, 20'h00040, 32'h0, lat, ce_cnt, oe_cnt, we_cnt, be_seen, rdata);
        check_eq("fb_after_store_lat", lat, 32'd3);
        check_eq("fb_after_store_ce", ce_cnt, 32'd2);
        check_eq("fb_after_store_rdata", rdata, 32'hFEEDFACE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
